filtered_inverter_bank: RTL and testbench

Parametrised multi-channel inverter with a per-channel programmable polarity and a digital glitch filter. Each channel registers its input, accepts a new level only after it has been stable for FILTER consecutive cycles, then drives the filtered level, optionally inverted, to its output. A transition counter and per-channel change pulses expose switching activity. The block replaces the single combinational CMOS inverter in designs that need clocked, noise-tolerant inversion across a bus.

---
 rtl/filtered_inverter_bank.sv | 103 ++++++++++
 tb/tb_filtered_inverter_bank.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filtered_inverter_bank.sv
// Multi-channel clocked inverter/buffer. Each channel has a glitch filter that accepts a new level
// only after FILTER stable cycles, and the block keeps a saturating count of accepted transitions.
module filtered_inverter_bank #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned FILTER = 4,
  parameter int unsigned EVT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] invert_mask,
  input  logic             clr_count,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] changed,
  output logic [EVT_W-1:0] edge_count
);

  localparam int unsigned CntW = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam int unsigned PcW  = $clog2(WIDTH + 1);
  localparam int unsigned SumW = EVT_W + PcW + 1;

  localparam logic [CntW-1:0] CntMax = CntW'(FILTER - 1);
  localparam logic [SumW-1:0] EvtMax = (SumW'(1) << EVT_W) - SumW'(1);

  logic [WIDTH-1:0] in_q, in_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];
  logic [WIDTH-1:0] changed_q;
  logic [EVT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] upd;
  logic [PcW-1:0]   pop;
  logic [SumW-1:0]  sum;

  always_comb begin
    in_d = in_q;
    f_d  = f_q;
    upd  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (en) begin
      in_d = in;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (in_q[i] == f_q[i]) begin
          // Input fell back to the accepted level: a pending change was a glitch.
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntMax) begin
          f_d[i]   = in_q[i];
          cnt_d[i] = '0;
          upd[i]   = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pop = pop + PcW'(upd[i]);
    end
    sum     = SumW'(count_q) + SumW'(pop);
    count_d = count_q;
    // Clear takes priority over any simultaneous increment and ignores en.
    if (clr_count) begin
      count_d = '0;
    end else if (sum > EvtMax) begin
      count_d = EvtMax[EVT_W-1:0];
    end else begin
      count_d = sum[EVT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q      <= '0;
      f_q       <= '0;
      changed_q <= '0;
      count_q   <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      in_q      <= in_d;
      f_q       <= f_d;
      changed_q <= upd;
      count_q   <= count_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Polarity is applied after the filter so mask changes never disturb filter state.
  assign out        = f_q ^ invert_mask;
  assign changed    = changed_q;
  assign edge_count = count_q;

endmodule

// File: tb/tb_filtered_inverter_bank.sv
// Bench for filtered_inverter_bank: directed scenarios plus random traffic, all checked against
// a run-length model of the glitch filter.
module tb_filtered_inverter_bank;

  localparam int unsigned W      = 8;
  localparam int unsigned FILT   = 4;
  localparam int unsigned EW     = 4;
  localparam int          MaxCnt = 15;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] din;
  logic [W-1:0] mask;
  logic         clr;
  logic [W-1:0] out_w;
  logic [W-1:0] chg_w;
  logic [EW-1:0] cnt_w;

  int errors;
  int checks;

  filtered_inverter_bank #(
    .WIDTH (W),
    .FILTER(FILT),
    .EVT_W (EW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in         (din),
    .invert_mask(mask),
    .clr_count  (clr),
    .out        (out_w),
    .changed    (chg_w),
    .edge_count (cnt_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a channel accepts the opposite level after FILTER consecutive enabled edges on which
  // its registered sample disagreed with the accepted level.
  logic [W-1:0] m_inq;
  logic [W-1:0] m_f;
  logic [W-1:0] m_chg;
  int           m_run [W];
  int           m_count;
  int           m_n;

  always @(posedge clk) begin
    if (rst) begin
      m_inq   = '0;
      m_f     = '0;
      m_chg   = '0;
      m_count = 0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      m_n   = 0;
      m_chg = '0;
      if (en) begin
        for (int i = 0; i < W; i++) begin
          if (m_inq[i] != m_f[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == FILT) begin
              m_f[i]   = ~m_f[i];
              m_run[i] = 0;
              m_chg[i] = 1'b1;
              m_n      = m_n + 1;
            end
          end else begin
            m_run[i] = 0;
          end
        end
        m_inq = din;
      end
      if (clr) m_count = 0;
      else m_count = (m_count + m_n > MaxCnt) ? MaxCnt : m_count + m_n;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din = '0;
    en  = 1'b1;
    clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    mask = 8'hFF;
    do_reset();
    checks++;
    if (out_w !== 8'hFF || chg_w !== 8'h00 || cnt_w !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: out=%h changed=%h count=%0d, required out=ff changed=00 count=0",
               out_w, chg_w, cnt_w);
    end
    din = 8'hFF;
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks++;
      if (e < 5 && out_w !== 8'hFF) begin
        errors++;
        $display("FAIL latency_early edge%0d: out=%h required ff", e, out_w);
      end else if (e == 5 && (out_w !== 8'h00 || chg_w !== 8'hFF || cnt_w !== 4'd8)) begin
        errors++;
        $display("FAIL latency_update: out=%h changed=%h count=%0d, required 00 ff 8",
                 out_w, chg_w, cnt_w);
      end
    end
    tick();
    checks++;
    if (chg_w !== 8'h00 || cnt_w !== 4'd8) begin
      errors++;
      $display("FAIL changed_one_cycle: changed=%h count=%0d, required 00 8", chg_w, cnt_w);
    end
  endtask

  task automatic test_glitch();
    mask = 8'hFF;
    do_reset();
    din = 8'h01;
    repeat (3) tick();
    din = 8'h00;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if (out_w[0] !== 1'b1 || chg_w !== 8'h00 || cnt_w !== 4'd0) begin
        errors++;
        $display("FAIL glitch_reject cyc%0d: out=%h changed=%h count=%0d, required ff 00 0",
                 e, out_w, chg_w, cnt_w);
      end
    end
    din = 8'h01;
    repeat (5) tick();
    checks++;
    if (out_w !== 8'hFE || chg_w !== 8'h01 || cnt_w !== 4'd1) begin
      errors++;
      $display("FAIL glitch_accept: out=%h changed=%h count=%0d, required fe 01 1",
               out_w, chg_w, cnt_w);
    end
  endtask

  task automatic test_mask();
    mask = 8'hF0;
    do_reset();
    din = 8'hAA;
    repeat (6) tick();
    checks++;
    if (out_w !== 8'h5A) begin
      errors++;
      $display("FAIL mask_f0: out=%h required 5a", out_w);
    end
    mask = 8'h0F;
    #1;
    checks++;
    if (out_w !== 8'hA5 || chg_w !== 8'h00) begin
      errors++;
      $display("FAIL mask_toggle: out=%h changed=%h, required a5 00", out_w, chg_w);
    end
    tick();
    checks++;
    if (chg_w !== 8'h00 || cnt_w !== 4'd4) begin
      errors++;
      $display("FAIL mask_no_event: changed=%h count=%0d, required 00 4", chg_w, cnt_w);
    end
  endtask

  task automatic test_freeze();
    mask = 8'h00;
    do_reset();
    din = 8'h08;
    repeat (3) tick();
    en = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      checks++;
      if (chg_w !== 8'h00 || out_w !== 8'h00) begin
        errors++;
        $display("FAIL freeze cyc%0d: out=%h changed=%h, required 00 00", e, out_w, chg_w);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if (out_w !== 8'h00) begin
      errors++;
      $display("FAIL resume_early: out=%h required 00", out_w);
    end
    tick();
    checks++;
    if (out_w !== 8'h08 || chg_w !== 8'h08) begin
      errors++;
      $display("FAIL resume_update: out=%h changed=%h, required 08 08", out_w, chg_w);
    end
  endtask

  task automatic test_saturation();
    mask = 8'h00;
    do_reset();
    for (int t = 0; t < 5; t++) begin
      din = din ^ 8'h0F;
      repeat (6) tick();
    end
    checks++;
    if (cnt_w !== 4'd15) begin
      errors++;
      $display("FAIL saturate: count=%0d required 15", cnt_w);
    end
    din = din ^ 8'h0F;
    repeat (4) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (cnt_w !== 4'd0 || chg_w !== 8'h0F) begin
      errors++;
      $display("FAIL clear_wins: count=%0d changed=%h, required 0 0f", cnt_w, chg_w);
    end
  endtask

  task automatic test_rst_mid();
    mask = 8'hA5;
    do_reset();
    din = 8'h20;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (out_w !== 8'hA5 || chg_w !== 8'h00 || cnt_w !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid: out=%h changed=%h count=%0d, required a5 00 0",
               out_w, chg_w, cnt_w);
    end
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks++;
      if (e < 5 && out_w !== 8'hA5) begin
        errors++;
        $display("FAIL rst_refilter edge%0d: out=%h required a5", e, out_w);
      end else if (e == 5 && out_w !== 8'h85) begin
        errors++;
        $display("FAIL rst_refilter_done: out=%h required 85", out_w);
      end
    end
  endtask

  task automatic test_random();
    mask = 8'h3C;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      din = din ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 15) == 0) mask = 8'($urandom);
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 99) == 0);
      tick();
      checks++;
      if (out_w !== (m_f ^ mask) || chg_w !== m_chg || int'(cnt_w) !== m_count) begin
        errors++;
        $display("FAIL random cyc%0d: out=%h changed=%h count=%0d, required %h %h %0d",
                 c, out_w, chg_w, cnt_w, m_f ^ mask, m_chg, m_count);
      end
    end
    rst = 1'b0;
    clr = 1'b0;
    en  = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    en     = 1'b1;
    din    = '0;
    mask   = '0;
    clr    = 1'b0;
    @(negedge clk);
    test_reset();
    test_glitch();
    test_mask();
    test_freeze();
    test_saturation();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
